ntt_coeff_loader: RTL and testbench

- Upstream feeder for the NTT core.
- Accepts one polynomial of 2^RING_DEPTH coefficients from the host over a valid/ready stream, reduces each coefficient once mod Q, and buffers it in a single-port-per-side RAM.
- Replays the buffer, bit-reversed, into the NTT's load_b window, then issues a one-cycle start or start_intt.
- Holds off new input until the NTT reports done.

---
 rtl/ntt_coeff_loader.sv | 183 ++++++++++++++++++
 tb/tb_ntt_coeff_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader: host-to-NTT coefficient feeder.
// Reduces mod Q, buffers one polynomial, replays it bit-reversed, then starts the NTT.
module ntt_coeff_loader #(
  parameter int DATA_SIZE_ARB = 32,
  parameter int RING_DEPTH    = 10,
  parameter int Q             = 12289,
  parameter bit BITREV        = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_SIZE_ARB-1:0] s_data,
  input  logic                     s_mode,
  output logic                     ntt_load_b,
  output logic [DATA_SIZE_ARB-1:0] ntt_din,
  output logic                     ntt_start,
  output logic                     ntt_start_intt,
  input  logic                     ntt_done,
  output logic                     busy,
  output logic                     range_err
);

  localparam int W  = DATA_SIZE_ARB;
  localparam int RD = RING_DEPTH;
  localparam int N  = 1 << RD;
  localparam int CW = RD + 1;

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [W-1:0]  Q_W    = W'(Q);
  localparam logic [W:0]    Q_X    = (W + 1)'(Q);
  localparam logic [W:0]    Q2_X   = Q_X << 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    GAP,
    START,
    WAIT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   wr_cnt_q;
  logic [CW-1:0]   rd_cnt_q;
  logic            mode_q;
  logic            s_ready_q;
  logic            load_b_q;
  logic            start_q;
  logic            start_intt_q;
  logic            busy_q;
  logic            range_err_q;
  logic            din_vld_q;
  logic [W-1:0]    rd_data_q;
  logic [W-1:0]    mem_q [N];

  logic            beat;
  logic            ge_q;
  logic            ge_2q;
  logic            wr_en;
  logic            rd_en;
  logic [W-1:0]    wr_data_d;
  logic [RD-1:0]   wr_addr_d;
  logic [RD-1:0]   rd_addr_d;

  function automatic logic [RD-1:0] brev(input logic [RD-1:0] a);
    logic [RD-1:0] r;
    r = '0;
    for (int i = 0; i < RD; i++) begin
      r[i] = a[RD-1-i];
    end
    return r;
  endfunction

  // Beat qualification, single conditional subtract, buffer addressing
  always_comb begin
    beat      = s_valid & s_ready_q;
    ge_q      = {1'b0, s_data} >= Q_X;
    ge_2q     = {1'b0, s_data} >= Q2_X;
    wr_data_d = ge_q ? (s_data - Q_W) : s_data;
    wr_addr_d = (state_q == IDLE) ? '0 : wr_cnt_q[RD-1:0];
    wr_en     = beat & ((state_q == IDLE) | (state_q == FILL));
    rd_en     = (state_q == LOAD) & (rd_cnt_q != N_C);
    rd_addr_d = BITREV ? brev(rd_cnt_q[RD-1:0])
                       : rd_cnt_q[RD-1:0];
  end

  // Coefficient buffer: one write port, one synchronous read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr_d];
    end
  end

  // Control FSM with registered handshake and NTT strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      mode_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      load_b_q     <= 1'b0;
      start_q      <= 1'b0;
      start_intt_q <= 1'b0;
      busy_q       <= 1'b0;
      range_err_q  <= 1'b0;
      din_vld_q    <= 1'b0;
    end else begin
      load_b_q     <= 1'b0;
      start_q      <= 1'b0;
      start_intt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (beat) begin
            mode_q      <= s_mode;
            range_err_q <= ge_2q;
            busy_q      <= 1'b1;
            wr_cnt_q    <= CW'(1);
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (beat) begin
            if (ge_2q) begin
              range_err_q <= 1'b1;
            end
            if (wr_cnt_q == LAST_C) begin
              s_ready_q <= 1'b0;
              load_b_q  <= 1'b1;
              rd_cnt_q  <= '0;
              state_q   <= LOAD;
            end else begin
              wr_cnt_q <= wr_cnt_q + CW'(1);
            end
          end
        end
        LOAD: begin
          if (rd_cnt_q != N_C) begin
            rd_cnt_q  <= rd_cnt_q + CW'(1);
            din_vld_q <= 1'b1;
          end else begin
            din_vld_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          start_q      <= ~mode_q;
          start_intt_q <= mode_q;
          state_q      <= START;
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (ntt_done) begin
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
            wr_cnt_q  <= '0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign ntt_load_b     = load_b_q;
  assign ntt_din        = din_vld_q ? rd_data_q : '0;
  assign ntt_start      = start_q;
  assign ntt_start_intt = start_intt_q;
  assign busy           = busy_q;
  assign range_err      = range_err_q;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// tb_ntt_coeff_loader: directed bench for the NTT coefficient loader.
// Two instances (BITREV=1 and BITREV=0) share one host stream.
module tb_ntt_coeff_loader;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_mode;
  logic        ntt_done;

  logic        rdy_br, lb_br, st_br, sti_br, busy_br, re_br;
  logic        rdy_nb, lb_nb, st_nb, sti_nb, busy_nb, re_nb;
  logic [31:0] din_br, din_nb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] d      [N];
  logic [31:0] cap_br [N];
  logic [31:0] cap_nb [N];
  logic        re_after [N];

  int lb_early, lb_at_t, lb_cnt, st_cnt, sti_cnt;
  int st_pos, sti_pos, outwin, timeouts;

  always #5 clk = ~clk;

  ntt_coeff_loader #(
    .DATA_SIZE_ARB(32), .RING_DEPTH(10), .Q(12289), .BITREV(1'b1)
  ) u_br (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(rdy_br),
    .s_data(s_data), .s_mode(s_mode),
    .ntt_load_b(lb_br), .ntt_din(din_br),
    .ntt_start(st_br), .ntt_start_intt(sti_br),
    .ntt_done(ntt_done), .busy(busy_br),
    .range_err(re_br)
  );

  ntt_coeff_loader #(
    .DATA_SIZE_ARB(32), .RING_DEPTH(10), .Q(12289), .BITREV(1'b0)
  ) u_nb (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(rdy_nb),
    .s_data(s_data), .s_mode(s_mode),
    .ntt_load_b(lb_nb), .ntt_din(din_nb),
    .ntt_start(st_nb), .ntt_start_intt(sti_nb),
    .ntt_done(ntt_done), .busy(busy_nb),
    .range_err(re_nb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) r = r | (1 << (9 - i));
    end
    return r;
  endfunction

  function automatic logic [31:0] reduce(input logic [31:0] x);
    if (x >= 32'd12289) return x - 32'd12289;
    return x;
  endfunction

  // Host side: one polynomial, optional 1/0 valid toggling
  task automatic send(input bit mode, input bit stall,
                      input bit spur);
    int bud;
    lb_early = 0;
    for (int i = 0; i < N; i++) begin
      bud     = 0;
      s_valid = 1'b1;
      s_data  = d[i];
      s_mode  = (i == 0) ? mode : ~mode;
      while (!rdy_br && bud < 50) begin
        @(posedge clk); #1;
        bud++;
      end
      if (bud >= 50) timeouts++;
      ntt_done = spur && (i == 100);
      @(posedge clk); #1;
      ntt_done    = 1'b0;
      re_after[i] = re_br;
      if (i < N - 1 && (lb_br || lb_nb)) lb_early++;
      s_valid = 1'b0;
      if (stall && i < N - 1) begin
        @(posedge clk); #1;
        if (lb_br || lb_nb) lb_early++;
      end
    end
  endtask

  // NTT side: observe cycles T .. T+N+3
  task automatic capture();
    lb_at_t = int'(lb_br);
    lb_cnt  = 0;
    st_cnt  = 0;
    sti_cnt = 0;
    st_pos  = -1;
    sti_pos = -1;
    outwin  = 0;
    for (int c = 0; c <= N + 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (lb_br) lb_cnt++;
      if (lb_nb) lb_cnt++;
      if (st_br) begin st_cnt++; st_pos = c; end
      if (st_nb) st_cnt++;
      if (sti_br) begin sti_cnt++; sti_pos = c; end
      if (sti_nb) sti_cnt++;
      if (c >= 1 && c <= N) begin
        cap_br[c-1] = din_br;
        cap_nb[c-1] = din_nb;
      end else if (din_br != 0 || din_nb != 0) begin
        outwin++;
      end
    end
  endtask

  task automatic check_run(input string tag, input bit mode);
    int eb, en;
    eb = 0;
    en = 0;
    for (int k = 0; k < N; k++) begin
      if (cap_br[k] !== reduce(d[brev(k)])) eb++;
      if (cap_nb[k] !== reduce(d[k])) en++;
    end
    chk({tag, "_lb_early"}, lb_early, 0);
    chk({tag, "_lb_at_T"}, lb_at_t, 1);
    chk({tag, "_lb_pulses"}, lb_cnt, 2);
    chk({tag, "_start_cnt"}, st_cnt, mode ? 0 : 2);
    chk({tag, "_intt_cnt"}, sti_cnt, mode ? 2 : 0);
    chk({tag, "_start_pos"}, mode ? sti_pos : st_pos, 1026);
    chk({tag, "_din_outside"}, outwin, 0);
    chk({tag, "_br_stream_errs"}, eb, 0);
    chk({tag, "_nb_stream_errs"}, en, 0);
    chk({tag, "_timeouts"}, timeouts, 0);
  endtask

  task automatic wait_done(input string tag, input bit hold);
    chk({tag, "_wait_ready"}, {rdy_br, rdy_nb}, 0);
    chk({tag, "_wait_busy"}, {busy_br, busy_nb}, 3);
    if (hold) begin
      s_valid = 1'b1;
      s_data  = 32'd777;
      repeat (5) begin
        @(posedge clk); #1;
      end
      chk({tag, "_hold_ready"}, {rdy_br, rdy_nb}, 0);
      chk({tag, "_hold_busy"}, {busy_br, busy_nb}, 3);
      s_valid = 1'b0;
    end
    ntt_done = 1'b1;
    @(posedge clk); #1;
    ntt_done = 1'b0;
    chk({tag, "_done_busy"}, {busy_br, busy_nb}, 0);
    chk({tag, "_done_ready"}, {rdy_br, rdy_nb}, 3);
  endtask

  initial begin
    int ab;
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_mode   = 1'b0;
    ntt_done = 1'b0;
    timeouts = 0;
    #1;
    chk("rst_ctrl",
        {lb_br, st_br, sti_br, busy_br, re_br, rdy_br}, 0);
    chk("rst_din", din_br | din_nb, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rel_ready_low", {rdy_br, rdy_nb}, 0);
    @(posedge clk); #1;
    chk("rel_ready_high", {rdy_br, rdy_nb}, 3);
    chk("rel_busy", {busy_br, busy_nb}, 0);

    // A: ramp, forward
    for (int k = 0; k < N; k++) d[k] = 32'(k);
    send(1'b0, 1'b0, 1'b0);
    capture();
    check_run("A", 1'b0);
    chk("A_br_k1", cap_br[1], 512);
    chk("A_br_k3", cap_br[3], 768);
    chk("A_nb_k3", cap_nb[3], 3);
    wait_done("A", 1'b0);

    // B: ramp, inverse
    send(1'b1, 1'b0, 1'b0);
    capture();
    check_run("B", 1'b1);
    chk("B_nb_k1023", cap_nb[1023], 1023);
    wait_done("B", 1'b0);

    // C: reduction boundaries
    for (int k = 0; k < N; k++) d[k] = 32'(k);
    d[0] = 32'd12288;
    d[1] = 32'd12289;
    d[2] = 32'd24577;
    d[5] = 32'd24578;
    send(1'b0, 1'b0, 1'b0);
    chk("C_re_after2", re_after[2], 0);
    chk("C_re_after4", re_after[4], 0);
    chk("C_re_after5", re_after[5], 1);
    chk("C_re_after1023", re_after[N-1], 1);
    capture();
    check_run("C", 1'b0);
    chk("C_red_12288", cap_nb[0], 12288);
    chk("C_red_12289", cap_nb[1], 0);
    chk("C_red_24577", cap_nb[2], 12288);
    chk("C_red_24578", cap_nb[5], 12289);
    wait_done("C", 1'b0);
    chk("C_re_sticky", {re_br, re_nb}, 3);

    // D: stalls, spurious done in FILL, valid held in WAIT
    for (int k = 0; k < N; k++) d[k] = 32'(3 * k + 5);
    send(1'b0, 1'b1, 1'b1);
    chk("D_re_cleared", re_after[0], 0);
    capture();
    check_run("D", 1'b0);
    wait_done("D", 1'b1);

    // E: reset during replay
    for (int k = 0; k < N; k++) d[k] = 32'(k + 100);
    send(1'b1, 1'b0, 1'b0);
    repeat (500) begin
      @(posedge clk); #1;
    end
    chk("E_mid_lb_din", din_nb, 32'(d[499]));
    reset = 1'b1;
    #1;
    chk("E_abort_ctrl",
        {lb_br, st_br, sti_br, busy_br, re_br, rdy_br,
         lb_nb, st_nb, sti_nb, busy_nb, re_nb, rdy_nb}, 0);
    chk("E_abort_din", din_br | din_nb, 0);
    ab = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (st_br || sti_br || st_nb || sti_nb || lb_br) ab++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    if (st_br || sti_br || st_nb || sti_nb || lb_br) ab++;
    chk("E_no_pulse", ab, 0);
    chk("E_ready_back", {rdy_br, rdy_nb}, 3);

    // F: fresh polynomial after abort
    for (int k = 0; k < N; k++) d[k] = 32'(2 * k + 1);
    send(1'b0, 1'b0, 1'b0);
    capture();
    check_run("F", 1'b0);
    wait_done("F", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
